// File: rtl/master_bridge_if.sv
// ---------------------------------------------------------------------------
// master_bridge_if
//
// External valid/ready bus between the master_bridge and a downstream target.
// The request channel (m_*) carries one access from bridge to target.
// The response channel (s_*) carries read data or a write acknowledge back.
//
// Signals:
//   m_valid  request valid, held until m_ready is seen
//   m_ready  request accepted by the target
//   m_addr   request offset (ADDR_W bits)
//   m_wdata  write data
//   m_wstrb  byte strobes, zero for reads
//   m_write  1 = write, 0 = read
//   s_rvalid response valid (read data or write ack)
//   s_rdata  response data
//   s_rerr   response error, qualified by s_rvalid
//
// Modports:
//   master   the bridge side (drives the request, receives the response)
//   slave    the target side
// ---------------------------------------------------------------------------
interface master_bridge_if #(
  parameter int ADDR_W = 16
);

  logic              m_valid;
  logic              m_ready;
  logic [ADDR_W-1:0] m_addr;
  logic [31:0]       m_wdata;
  logic [3:0]        m_wstrb;
  logic              m_write;
  logic              s_rvalid;
  logic [31:0]       s_rdata;
  logic              s_rerr;

  modport master (
    output m_valid, m_addr, m_wdata, m_wstrb, m_write,
    input  m_ready, s_rvalid, s_rdata, s_rerr
  );

  modport slave (
    input  m_valid, m_addr, m_wdata, m_wstrb, m_write,
    output m_ready, s_rvalid, s_rdata, s_rerr
  );

endinterface

// File: rtl/master_bridge.sv
// ---------------------------------------------------------------------------
// master_bridge
//
// Serves the master address region behind the CPU address decoder. When the
// decoder selects this block, the CPU access is captured and one transaction
// runs on the external valid/ready bus. Read data is returned to the CPU mux,
// and a one-cycle done pulse releases the decoder's CPU stall. A watchdog
// forces completion if the bus never answers, so the CPU cannot hang.
//
// Ports:
//   clk           single rising-edge clock
//   rst_n         asynchronous active-low reset
//   en_MASTER     decoder select for the master region
//   daddr         CPU data address (offset = daddr - BASE_ADDR)
//   dwdata        CPU write data
//   we_i          raw CPU byte write enables; any bit set means write
//   bus           external request/response bus (master side)
//   drdata_master read data returned to the CPU mux
//   done_master   one-cycle completion pulse to the decoder
//   err_flag      sticky error: timeout or bus error response
//   err_clr       synchronous clear of err_flag (an error being set wins)
// ---------------------------------------------------------------------------
module master_bridge #(
  parameter int          BASE_ADDR = 11001,
  parameter int          ADDR_W    = 16,
  parameter int          TIMEOUT   = 255,
  parameter logic [31:0] ERR_DATA  = 32'hDEADBEEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_MASTER,
  input  logic [31:0]           daddr,
  input  logic [31:0]           dwdata,
  input  logic [3:0]            we_i,
  master_bridge_if.master       bus,
  output logic [31:0]           drdata_master,
  output logic                  done_master,
  output logic                  err_flag,
  input  logic                  err_clr
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [7:0]        r_cnt;
  logic              r_valid;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_wstrb;
  logic              r_write;
  logic [31:0]       r_rdata;
  logic              r_done;
  logic              r_err;

  logic [ADDR_W-1:0] w_offset;
  logic [8:0]        w_cntNext;
  logic              w_cntExpired;
  logic              w_timeoutHit;
  logic              w_respErr;

  // Bus offset relative to the start of the master region, truncated to the
  // external address width.
  assign w_offset = ADDR_W'(daddr - 32'(BASE_ADDR));

  // The count is computed one bit wider so the comparison cannot wrap.
  assign w_cntNext    = {1'b0, r_cnt} + 9'd1;
  assign w_cntExpired = (w_cntNext >= 9'(TIMEOUT));

  // The watchdog fires only when the handshake expected in the current state
  // is absent; a handshake in the same cycle takes priority.
  assign w_timeoutHit = w_cntExpired &&
                        (((r_state == S_REQ)  && !bus.m_ready) ||
                         ((r_state == S_RESP) && !bus.s_rvalid));

  assign w_respErr = (r_state == S_RESP) && bus.s_rvalid && bus.s_rerr;

  // Controller, request registers, read data, done pulse and sticky error.
  // All outputs are registered, so nothing on the bus reaches done_master
  // combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 32'd0;
      r_wstrb <= 4'd0;
      r_write <= 1'b0;
      r_rdata <= 32'd0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (w_respErr || w_timeoutHit) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end

      unique case (r_state)
        S_IDLE: begin
          if (en_MASTER) begin
            r_addr  <= w_offset;
            r_wdata <= dwdata;
            r_wstrb <= we_i;
            r_write <= |we_i;
            r_cnt   <= 8'd0;
            r_valid <= 1'b1;
            r_state <= S_REQ;
          end
        end

        S_REQ: begin
          // Saturate so a late accept still leaves RESP guarded.
          r_cnt <= w_cntNext[8] ? 8'hFF : w_cntNext[7:0];
          if (bus.m_ready) begin
            r_valid <= 1'b0;
            r_state <= S_RESP;
          end else if (w_timeoutHit) begin
            r_valid <= 1'b0;
            if (!r_write) begin
              r_rdata <= ERR_DATA;
            end
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end

        S_RESP: begin
          r_cnt <= w_cntNext[8] ? 8'hFF : w_cntNext[7:0];
          if (bus.s_rvalid) begin
            if (!r_write) begin
              r_rdata <= bus.s_rdata;
            end
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (w_timeoutHit) begin
            if (!r_write) begin
              r_rdata <= ERR_DATA;
            end
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end

        S_DONE: begin
          // A select still high here belongs to the access just finished.
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.m_valid    = r_valid;
  assign bus.m_addr     = r_addr;
  assign bus.m_wdata    = r_wdata;
  assign bus.m_wstrb    = r_wstrb;
  assign bus.m_write    = r_write;
  assign drdata_master  = r_rdata;
  assign done_master    = r_done;
  assign err_flag       = r_err;

endmodule

// File: tb/tb_master_bridge.sv
// ---------------------------------------------------------------------------
// tb_master_bridge
//
// Directed testbench for master_bridge. The bridge is built with a short
// watchdog (TIMEOUT = 8) so the timeout case runs quickly. The bench plays
// both the CPU/decoder side and the external bus target, and compares DUT
// outputs against hand-computed values.
// ---------------------------------------------------------------------------
module tb_master_bridge;

  localparam int ADDR_W = 16;
  localparam int BASE   = 11001;

  logic        clk;
  logic        rst_n;
  logic        en_MASTER;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [3:0]  we_i;
  logic [31:0] drdata_master;
  logic        done_master;
  logic        err_flag;
  logic        err_clr;

  int assertCount;
  int failCount;

  master_bridge_if #(.ADDR_W(ADDR_W)) busIf ();

  master_bridge #(
    .BASE_ADDR(BASE),
    .ADDR_W   (ADDR_W),
    .TIMEOUT  (8),
    .ERR_DATA (32'hDEADBEEF)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_MASTER    (en_MASTER),
    .daddr        (daddr),
    .dwdata       (dwdata),
    .we_i         (we_i),
    .bus          (busIf.master),
    .drdata_master(drdata_master),
    .done_master  (done_master),
    .err_flag     (err_flag),
    .err_clr      (err_clr)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] we);
    en_MASTER = en;
    daddr     = addr;
    dwdata    = wdata;
    we_i      = we;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int waited;
    int doneCount;
    int firstDone;
    int secondDone;
    logic prevHs;

    assertCount = 0;
    failCount   = 0;
    rst_n       = 1'b0;
    err_clr     = 1'b0;
    applyStimulus(1'b0, 32'd0, 32'd0, 4'd0);
    busIf.m_ready  = 1'b0;
    busIf.s_rvalid = 1'b0;
    busIf.s_rdata  = 32'd0;
    busIf.s_rerr   = 1'b0;

    // Reset state
    tick();
    tick();
    checkOutput("rst_done",   32'(done_master),   32'd0);
    checkOutput("rst_valid",  32'(busIf.m_valid), 32'd0);
    checkOutput("rst_addr",   32'(busIf.m_addr),  32'd0);
    checkOutput("rst_wstrb",  32'(busIf.m_wstrb), 32'd0);
    checkOutput("rst_write",  32'(busIf.m_write), 32'd0);
    checkOutput("rst_rdata",  drdata_master,      32'd0);
    checkOutput("rst_err",    32'(err_flag),      32'd0);
    rst_n = 1'b1;

    // Read, zero wait states
    applyStimulus(1'b1, 32'(BASE + 32'h40), 32'd0, 4'b0000);
    tick();
    applyStimulus(1'b0, 32'd0, 32'd0, 4'd0);
    checkOutput("rd_valid", 32'(busIf.m_valid), 32'd1);
    checkOutput("rd_addr",  32'(busIf.m_addr),  32'h40);
    checkOutput("rd_write", 32'(busIf.m_write), 32'd0);
    checkOutput("rd_wstrb", 32'(busIf.m_wstrb), 32'd0);
    checkOutput("rd_nodone1", 32'(done_master), 32'd0);
    busIf.m_ready = 1'b1;
    tick();
    busIf.m_ready = 1'b0;
    checkOutput("rd_valid_drop", 32'(busIf.m_valid), 32'd0);
    checkOutput("rd_nodone2", 32'(done_master), 32'd0);
    busIf.s_rvalid = 1'b1;
    busIf.s_rdata  = 32'h12345678;
    tick();
    busIf.s_rvalid = 1'b0;
    checkOutput("rd_done",  32'(done_master), 32'd1);
    checkOutput("rd_rdata", drdata_master,    32'h12345678);
    checkOutput("rd_err",   32'(err_flag),    32'd0);
    tick();
    checkOutput("rd_done_pulse", 32'(done_master), 32'd0);

    // Write with four cycles of backpressure
    applyStimulus(1'b1, 32'd11005, 32'hA5A5A5A5, 4'b0011);
    tick();
    applyStimulus(1'b0, 32'd0, 32'd0, 4'd0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("wr_valid", 32'(busIf.m_valid), 32'd1);
      checkOutput("wr_addr",  32'(busIf.m_addr),  32'd4);
      checkOutput("wr_wdata", busIf.m_wdata,      32'hA5A5A5A5);
      checkOutput("wr_wstrb", 32'(busIf.m_wstrb), 32'b0011);
      checkOutput("wr_write", 32'(busIf.m_write), 32'd1);
      checkOutput("wr_nodone", 32'(done_master),  32'd0);
      tick();
    end
    busIf.m_ready = 1'b1;
    tick();
    busIf.m_ready = 1'b0;
    checkOutput("wr_valid_drop", 32'(busIf.m_valid), 32'd0);
    busIf.s_rvalid = 1'b1;
    busIf.s_rdata  = 32'hFFFFFFFF;
    tick();
    busIf.s_rvalid = 1'b0;
    checkOutput("wr_done",  32'(done_master), 32'd1);
    checkOutput("wr_rdata_kept", drdata_master, 32'h12345678);
    tick();
    checkOutput("wr_done_pulse", 32'(done_master), 32'd0);

    // Timeout: the target never accepts
    applyStimulus(1'b1, 32'(BASE), 32'd0, 4'd0);
    tick();
    applyStimulus(1'b0, 32'd0, 32'd0, 4'd0);
    checkOutput("to_valid", 32'(busIf.m_valid), 32'd1);
    waited = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      waited++;
      if (done_master) break;
    end
    checkOutput("to_latency", 32'(waited),        32'd8);
    checkOutput("to_rdata",   drdata_master,      32'hDEADBEEF);
    checkOutput("to_err",     32'(err_flag),      32'd1);
    checkOutput("to_valid_drop", 32'(busIf.m_valid), 32'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checkOutput("to_err_clr", 32'(err_flag), 32'd0);

    // Response error
    applyStimulus(1'b1, 32'(BASE + 32'h10), 32'd0, 4'd0);
    tick();
    applyStimulus(1'b0, 32'd0, 32'd0, 4'd0);
    busIf.m_ready = 1'b1;
    tick();
    busIf.m_ready  = 1'b0;
    busIf.s_rvalid = 1'b1;
    busIf.s_rerr   = 1'b1;
    busIf.s_rdata  = 32'h0BADF00D;
    tick();
    busIf.s_rvalid = 1'b0;
    busIf.s_rerr   = 1'b0;
    checkOutput("rerr_done",  32'(done_master), 32'd1);
    checkOutput("rerr_flag",  32'(err_flag),    32'd1);
    checkOutput("rerr_rdata", drdata_master,    32'h0BADF00D);
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checkOutput("rerr_clr", 32'(err_flag), 32'd0);

    // Error and clear in the same cycle: the error wins
    applyStimulus(1'b1, 32'(BASE + 32'h20), 32'd0, 4'd0);
    tick();
    applyStimulus(1'b0, 32'd0, 32'd0, 4'd0);
    busIf.m_ready = 1'b1;
    tick();
    busIf.m_ready  = 1'b0;
    busIf.s_rvalid = 1'b1;
    busIf.s_rerr   = 1'b1;
    busIf.s_rdata  = 32'h55AA55AA;
    err_clr        = 1'b1;
    tick();
    busIf.s_rvalid = 1'b0;
    busIf.s_rerr   = 1'b0;
    err_clr        = 1'b0;
    checkOutput("coll_flag", 32'(err_flag),    32'd1);
    checkOutput("coll_done", 32'(done_master), 32'd1);
    tick();

    // Reset during RESP, then a stray response
    applyStimulus(1'b1, 32'(BASE + 32'h30), 32'h11112222, 4'b1111);
    tick();
    applyStimulus(1'b0, 32'd0, 32'd0, 4'd0);
    busIf.m_ready = 1'b1;
    tick();
    busIf.m_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("mrst_done",  32'(done_master),   32'd0);
    checkOutput("mrst_valid", 32'(busIf.m_valid), 32'd0);
    checkOutput("mrst_addr",  32'(busIf.m_addr),  32'd0);
    checkOutput("mrst_wdata", busIf.m_wdata,      32'd0);
    checkOutput("mrst_wstrb", 32'(busIf.m_wstrb), 32'd0);
    checkOutput("mrst_write", 32'(busIf.m_write), 32'd0);
    checkOutput("mrst_rdata", drdata_master,      32'd0);
    checkOutput("mrst_err",   32'(err_flag),      32'd0);
    tick();
    rst_n = 1'b1;
    busIf.s_rvalid = 1'b1;
    busIf.s_rdata  = 32'h77777777;
    tick();
    busIf.s_rvalid = 1'b0;
    checkOutput("stray_done",  32'(done_master), 32'd0);
    checkOutput("stray_rdata", drdata_master,    32'd0);
    tick();
    checkOutput("stray_done2", 32'(done_master),   32'd0);
    checkOutput("stray_valid", 32'(busIf.m_valid), 32'd0);

    // Back-to-back reads with en_MASTER held high; the target accepts at
    // once and answers in the following cycle.
    doneCount  = 0;
    firstDone  = -1;
    secondDone = -1;
    prevHs     = 1'b0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      if (cyc == 1) checkOutput("b2b_addr1", 32'(busIf.m_addr), 32'd8);
      if (cyc == 5) checkOutput("b2b_addr2", 32'(busIf.m_addr), 32'd12);
      if (done_master) begin
        doneCount++;
        if (firstDone < 0) firstDone = cyc;
        else               secondDone = cyc;
        checkOutput("b2b_rdata", drdata_master, 32'h1000 + 32'(cyc - 1));
      end
      busIf.m_ready  = busIf.m_valid;
      busIf.s_rvalid = prevHs;
      busIf.s_rdata  = 32'h1000 + 32'(cyc);
      prevHs         = busIf.m_valid;
      applyStimulus(doneCount < 2, (doneCount >= 1) ? 32'(BASE + 12) : 32'(BASE + 8),
                    32'd0, 4'd0);
      tick();
    end
    busIf.m_ready  = 1'b0;
    busIf.s_rvalid = 1'b0;
    applyStimulus(1'b0, 32'd0, 32'd0, 4'd0);
    checkOutput("b2b_count",  32'(doneCount),  32'd2);
    checkOutput("b2b_first",  32'(firstDone),  32'd3);
    checkOutput("b2b_second", 32'(secondDone), 32'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/master_bridge.md
# master_bridge

Downstream of the CPU address decoder, serving the master region (daddr > 11000). When the decoder asserts `en_MASTER`, this block captures the CPU access, runs one transaction on an external valid/ready bus, and returns read data. It pulses `done_master` for one cycle to release the decoder's CPU stall. A timeout watchdog guarantees the CPU is never stalled forever.

## Interface
Parameters:
- BASE_ADDR, 11001: first byte address of the master region; bus offset = daddr - BASE_ADDR.
- ADDR_W, 16: external bus address width; the offset is truncated to ADDR_W bits.
- TIMEOUT, 255: maximum cycles spent in REQ+RESP before forced completion (8-bit counter).
- ERR_DATA, 32'hDEADBEEF: read data returned on timeout.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- en_MASTER  in  1  decoder select for the master region.
- daddr  in  32  CPU data address.
- dwdata  in  32  CPU write data.
- we_i  in  4  raw CPU byte write enables, not the decoder-masked copy; write = |we_i.
- drdata_master  out  32  read data returned to CPU mux.
- done_master  out  1  one-cycle completion pulse to the decoder.
- m_valid  out  1  request valid.
- m_ready  in  1  request accepted.
- m_addr  out  ADDR_W  request offset.
- m_wdata  out  32  write data.
- m_wstrb  out  4  byte strobes (0 for reads).
- m_write  out  1  1 = write, 0 = read.
- s_rvalid  in  1  response valid (read data or write ack).
- s_rdata  in  32  response data.
- s_rerr  in  1  response error, qualified by s_rvalid.
- err_flag  out  1  sticky error (timeout or s_rerr).
- err_clr  in  1  synchronous clear of err_flag.

## Operation
- States: IDLE, REQ, RESP, DONE.
- IDLE:
  - If en_MASTER=1, capture m_addr, m_wdata, m_wstrb, m_write from daddr, dwdata and we_i.
  - Clear the timeout counter and go to REQ.
- REQ:
  - m_valid=1 with the request fields held stable.
  - m_ready=1 goes to RESP; m_valid stays 1 until that handshake.
- RESP:
  - m_valid=0. On s_rvalid=1, go to DONE.
  - Reads load drdata_master from s_rdata. Writes leave drdata_master unchanged.
  - s_rerr=1 with s_rvalid sets err_flag.
- DONE:
  - done_master=1 for exactly one cycle, then IDLE.
  - en_MASTER seen during DONE belongs to the finished access and is ignored.
- Timeout:
  - The counter increments each cycle in REQ or RESP.
  - If it reaches TIMEOUT without a completing handshake, go to DONE and set err_flag.
  - Reads return ERR_DATA. m_valid drops immediately.
- s_rvalid outside RESP is ignored; it cannot complete a request in the acceptance cycle.
- err_flag: set wins over err_clr in the same cycle. It is cleared only by err_clr or reset.

## Timing
- Reset values: state IDLE, drdata_master=0, done_master=0, m_valid=0, m_addr=0, m_wdata=0, m_wstrb=0, m_write=0, err_flag=0, counter=0.
- Reset mid-transaction aborts immediately. A bus response arriving after reset is ignored.
- Minimum latency, with en_MASTER first seen at cycle 0:
  - m_valid=1 at cycle 1.
  - m_ready at cycle 1 gives RESP at cycle 2.
  - s_rvalid at cycle 2 gives done_master=1 at cycle 3.
- drdata_master is valid in the done_master cycle and held until the next completion.
- Simultaneous completion and timeout: a handshake in the cycle the counter hits TIMEOUT wins. Normal completion, no error.
- Back-to-back: en_MASTER high in the cycle after DONE starts a new transaction from IDLE.
- done_master is registered, with no combinational path from bus inputs.

## Test plan
- Read, zero-wait:
  - Stimulus: daddr=11001+0x40, we_i=0, m_ready=1 at cycle 1, s_rvalid with s_rdata=0x12345678 at cycle 2.
  - Required: m_addr=0x0040, m_write=0, done_master at cycle 3, drdata_master=0x12345678.
- Write with backpressure:
  - Stimulus: daddr=11005, dwdata=0xA5A5A5A5, we_i=4'b0011, m_ready low for 4 cycles, then ack.
  - Required: m_valid held with stable fields, m_wstrb=0011, m_addr=4, one done_master pulse, drdata_master unchanged.
- Timeout:
  - Stimulus: TIMEOUT=8, read with m_ready never asserted.
  - Required: done_master 8 cycles after REQ entry, drdata_master=0xDEADBEEF, err_flag=1. err_clr then returns err_flag to 0.
- Response error and collision:
  - Stimulus 1: s_rvalid with s_rerr=1. Required: err_flag=1.
  - Stimulus 2: err_clr asserted in the same cycle as the error. Required: err_flag remains 1.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 in RESP, release, then send a stray s_rvalid.
  - Required: all outputs return to reset values at once, no done_master, the stray response is ignored.
- Back-to-back:
  - Stimulus: two consecutive master reads with en_MASTER continuously high.
  - Required: exactly two done_master pulses separated by at least 3 cycles, with the second request fields captured after DONE.
